// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine
//   Integer matrix multiply C = A*B (or C += A*B) for an M x K by K x N problem,
//   computed on an M x N grid of multiply-accumulate PEs with skewed operand feed.
//
// Ports
//   clk_i, reset_i         rising-edge clock, synchronous active-high reset
//   en_i                   global stall when low (all registers hold, ready/valid low)
//   flush_i                abort: back to LOAD_A, counters and accumulators cleared
//   accumulate_i           captured on the first A beat; 1 keeps C as the starting sum
//   valid_i/ready_o/data_i operand input: A row-major, then B row-major
//   valid_o/yumi_i/data_o  result output, one C element per beat, row-major
//   busy_o                 high while in COMPUTE
//   state_o                0 LOAD_A, 1 LOAD_B, 2 COMPUTE, 3 DRAIN
//
// Handshakes: an operand beat transfers on a rising edge where valid_i & ready_o.
// A result transfers on a rising edge where valid_o & yumi_i; data_o is held
// stable while valid_o=1 and yumi_i=0. yumi_i without valid_o is ignored.
module systolic_matmul_engine #(
    parameter int width_p        = 8,
    parameter int acc_width_p    = 32,
    parameter int array_height_p = 2,
    parameter int array_width_p  = 2,
    parameter int inner_dim_p    = 2,
    parameter int signed_p       = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   flush_i,
    input  logic                   accumulate_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     data_i,
    output logic                   valid_o,
    input  logic                   yumi_i,
    output logic [acc_width_p-1:0] data_o,
    output logic                   busy_o,
    output logic [1:0]             state_o
);
    localparam int M        = array_height_p;
    localparam int N        = array_width_p;
    localparam int K        = inner_dim_p;
    localparam int A_BEATS  = M * K;
    localparam int B_BEATS  = K * N;
    localparam int C_CYCLES = K + M + N - 1;
    localparam int C_ELEMS  = M * N;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    localparam int CNT_MAX = max2(max2(A_BEATS, B_BEATS), max2(C_CYCLES, C_ELEMS));
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] A_LAST = CW'(A_BEATS - 1);
    localparam logic [CW-1:0] B_LAST = CW'(B_BEATS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(C_CYCLES - 1);
    localparam logic [CW-1:0] E_LAST = CW'(C_ELEMS - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    state_e                 state_q, state_n;
    logic [CW-1:0]          cnt_q;       // beat index, compute cycle or drain index
    logic                   acc_flag_q;
    logic                   valid_q;
    logic [acc_width_p-1:0] data_q;

    logic [width_p-1:0]     a_buf [A_BEATS];
    logic [width_p-1:0]     b_buf [B_BEATS];
    logic [width_p-1:0]     a_pe  [M][N];
    logic [width_p-1:0]     b_pe  [M][N];
    logic [acc_width_p-1:0] acc_q [M][N];

    logic [width_p-1:0]     feed_a [M];
    logic [width_p-1:0]     feed_b [N];
    logic [width_p-1:0]     a_in   [M][N];
    logic [width_p-1:0]     b_in   [M][N];
    logic [acc_width_p-1:0] prod   [M][N];
    logic [acc_width_p-1:0] c_sel;
    logic [CW-1:0]          sel_idx;
    logic                   accept;

    // Full-precision product, then sign/zero-extended (or truncated) to the
    // accumulator width so the sum wraps modulo 2^acc_width_p.
    function automatic logic [acc_width_p-1:0] mul_ext(input logic [width_p-1:0] a,
                                                       input logic [width_p-1:0] b);
        logic [2*width_p-1:0]             a2, b2, p;
        logic [acc_width_p+2*width_p-1:0] wide;
        logic                             s;
        a2   = (signed_p != 0) ? {{width_p{a[width_p-1]}}, a} : {{width_p{1'b0}}, a};
        b2   = (signed_p != 0) ? {{width_p{b[width_p-1]}}, b} : {{width_p{1'b0}}, b};
        p    = a2 * b2;
        s    = (signed_p != 0) ? p[2*width_p-1] : 1'b0;
        wide = {{acc_width_p{s}}, p};
        return wide[acc_width_p-1:0];
    endfunction

    assign ready_o = en_i & ~flush_i & ((state_q == LOAD_A) | (state_q == LOAD_B));
    assign accept  = valid_i & ready_o;
    assign valid_o = en_i & valid_q;
    assign data_o  = data_q;
    assign busy_o  = (state_q == COMPUTE);
    assign state_o = state_q;

    // Skewed feed: row r of A reaches column 0 delayed r cycles, column c of B
    // reaches row 0 delayed c cycles; zeros outside the operand window.
    always_comb begin
        for (int r = 0; r < M; r++) feed_a[r] = '0;
        for (int c = 0; c < N; c++) feed_b[c] = '0;
        if (state_q == COMPUTE) begin
            for (int r = 0; r < M; r++)
                for (int k = 0; k < K; k++)
                    if (cnt_q == CW'(r + k)) feed_a[r] = a_buf[r*K + k];
            for (int c = 0; c < N; c++)
                for (int k = 0; k < K; k++)
                    if (cnt_q == CW'(c + k)) feed_b[c] = b_buf[k*N + c];
        end
    end

    always_comb begin
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) begin
                a_in[r][c] = '0;
                b_in[r][c] = '0;
            end
        for (int r = 0; r < M; r++) a_in[r][0] = feed_a[r];
        for (int r = 0; r < M; r++)
            for (int c = 1; c < N; c++) a_in[r][c] = a_pe[r][c-1];
        for (int c = 0; c < N; c++) b_in[0][c] = feed_b[c];
        for (int r = 1; r < M; r++)
            for (int c = 0; c < N; c++) b_in[r][c] = b_pe[r-1][c];
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) prod[r][c] = mul_ext(a_in[r][c], b_in[r][c]);
    end

    // First DRAIN cycle loads C[cnt]; afterwards each yumi loads C[cnt+1].
    always_comb begin
        sel_idx = valid_q ? (cnt_q + CW'(1)) : cnt_q;
        c_sel   = '0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                if (sel_idx == CW'(r*N + c)) c_sel = acc_q[r][c];
    end

    always_comb begin
        state_n = state_q;
        if (en_i) begin
            if (flush_i) begin
                state_n = LOAD_A;
            end else begin
                case (state_q)
                    LOAD_A:  if (accept && cnt_q == A_LAST) state_n = LOAD_B;
                    LOAD_B:  if (accept && cnt_q == B_LAST) state_n = COMPUTE;
                    COMPUTE: if (cnt_q == C_LAST) state_n = DRAIN;
                    DRAIN:   if (valid_q && yumi_i && cnt_q == E_LAST) state_n = LOAD_A;
                    default: state_n = LOAD_A;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= LOAD_A;
        else         state_q <= state_n;
    end

    // Operand buffers need no reset: they are always written before being read.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < A_BEATS; i++)
                if (state_q == LOAD_A && cnt_q == CW'(i)) a_buf[i] <= data_i;
            for (int i = 0; i < B_BEATS; i++)
                if (state_q == LOAD_B && cnt_q == CW'(i)) b_buf[i] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || (en_i && flush_i)) begin
            cnt_q      <= '0;
            acc_flag_q <= 1'b0;
            valid_q    <= 1'b0;
            if (reset_i) data_q <= '0;
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++) begin
                    a_pe[r][c]  <= '0;
                    b_pe[r][c]  <= '0;
                    acc_q[r][c] <= '0;
                end
        end else if (en_i) begin
            case (state_q)
                LOAD_A: if (accept) begin
                    if (cnt_q == '0) acc_flag_q <= accumulate_i;
                    cnt_q <= (cnt_q == A_LAST) ? '0 : cnt_q + CW'(1);
                end
                LOAD_B: if (accept) begin
                    cnt_q <= (cnt_q == B_LAST) ? '0 : cnt_q + CW'(1);
                end
                COMPUTE: begin
                    // Cycle 0 either restarts the sums or continues from the last C.
                    for (int r = 0; r < M; r++)
                        for (int c = 0; c < N; c++) begin
                            a_pe[r][c]  <= a_in[r][c];
                            b_pe[r][c]  <= b_in[r][c];
                            acc_q[r][c] <= ((cnt_q == '0 && !acc_flag_q) ? '0 : acc_q[r][c])
                                           + prod[r][c];
                        end
                    cnt_q <= (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
                end
                DRAIN: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        data_q  <= c_sel;
                    end else if (yumi_i) begin
                        if (cnt_q == E_LAST) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_q + CW'(1);
                            data_q <= c_sel;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed bench for systolic_matmul_engine. Four instances share the input
// controls; only the selected one sees valid_i, and its outputs are observed.
//   inst 0: defaults (2x2x2, unsigned, 32-bit)
//   inst 1: signed, 16-bit accumulator
//   inst 2: M=2, K=3, N=1
//   inst 3: 8-bit accumulator
module tb_systolic_matmul_engine;
    logic       clk = 1'b0;
    logic       reset, en, flush, accum, yumi, vin;
    logic [7:0] din;
    int         sel;
    int         tests, fails;

    logic        vsel [4];
    logic        rdy  [4];
    logic        vo   [4];
    logic        bsy  [4];
    logic [1:0]  st   [4];
    logic [31:0] d0, d2;
    logic [15:0] d1;
    logic [7:0]  d3;

    logic        obs_ready, obs_valid, obs_busy;
    logic [1:0]  obs_state;
    logic [31:0] obs_data;

    logic [7:0]  a_v [6];
    logic [7:0]  b_v [6];
    logic [31:0] got [4];
    int          lat, busy_n;
    logic        rdy_seen;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) vsel[i] = vin & (sel == i);
    end

    always_comb begin
        obs_ready = rdy[0]; obs_valid = vo[0]; obs_busy = bsy[0]; obs_state = st[0];
        obs_data  = d0;
        case (sel)
            1: begin obs_ready = rdy[1]; obs_valid = vo[1]; obs_busy = bsy[1];
                     obs_state = st[1]; obs_data = {16'h0, d1}; end
            2: begin obs_ready = rdy[2]; obs_valid = vo[2]; obs_busy = bsy[2];
                     obs_state = st[2]; obs_data = d2; end
            3: begin obs_ready = rdy[3]; obs_valid = vo[3]; obs_busy = bsy[3];
                     obs_state = st[3]; obs_data = {24'h0, d3}; end
            default: ;
        endcase
    end

    systolic_matmul_engine u0 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .flush_i(flush), .accumulate_i(accum),
        .valid_i(vsel[0]), .ready_o(rdy[0]), .data_i(din), .valid_o(vo[0]), .yumi_i(yumi),
        .data_o(d0), .busy_o(bsy[0]), .state_o(st[0]));

    systolic_matmul_engine #(.signed_p(1), .acc_width_p(16)) u1 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .flush_i(flush), .accumulate_i(accum),
        .valid_i(vsel[1]), .ready_o(rdy[1]), .data_i(din), .valid_o(vo[1]), .yumi_i(yumi),
        .data_o(d1), .busy_o(bsy[1]), .state_o(st[1]));

    systolic_matmul_engine #(.array_height_p(2), .array_width_p(1), .inner_dim_p(3)) u2 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .flush_i(flush), .accumulate_i(accum),
        .valid_i(vsel[2]), .ready_o(rdy[2]), .data_i(din), .valid_o(vo[2]), .yumi_i(yumi),
        .data_o(d2), .busy_o(bsy[2]), .state_o(st[2]));

    systolic_matmul_engine #(.acc_width_p(8)) u3 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .flush_i(flush), .accumulate_i(accum),
        .valid_i(vsel[3]), .ready_o(rdy[3]), .data_i(din), .valid_o(vo[3]), .yumi_i(yumi),
        .data_o(d3), .busy_o(bsy[3]), .state_o(st[3]));

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] d);
        int n;
        n   = 0;
        vin = 1'b1;
        din = d;
        #1;
        while (!obs_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL send_ready_timeout ready=%0b required 1", obs_ready);
        end
        @(negedge clk);
        vin = 1'b0;
    endtask

    task automatic load(input int na, input int nb);
        for (int i = 0; i < na; i++) send(a_v[i]);
        for (int i = 0; i < nb; i++) send(b_v[i]);
    endtask

    task automatic set4(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
        a_v[0] = a0; a_v[1] = a1; a_v[2] = a2; a_v[3] = a3;
        b_v[0] = b0; b_v[1] = b1; b_v[2] = b2; b_v[3] = b3;
    endtask

    // Counts cycles from the last B-beat edge until valid_o rises.
    task automatic wait_valid();
        lat    = 0;
        busy_n = 0;
        #1;
        while (!obs_valid && lat < 200) begin
            if (obs_busy) busy_n++;
            @(negedge clk); #1; lat++;
        end
    endtask

    task automatic take(input int n);
        rdy_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            got[i]   = obs_data;
            rdy_seen = rdy_seen | obs_ready;
            yumi     = 1'b1;
            @(negedge clk); #1;
        end
        yumi = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sel = 0; reset = 1'b1; en = 1'b1; flush = 1'b0; accum = 1'b0;
        yumi = 1'b0; vin = 1'b0; din = 8'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (obs_state !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", obs_state); end
        tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%0b exp=1", obs_ready); end
        tests++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", obs_valid); end
        tests++; if (obs_data !== 32'h0) begin fails++; $display("FAIL reset_data got=%0h exp=0", obs_data); end
        tests++; if (obs_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b exp=0", obs_busy); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_v [4];
        exp_v = '{32'd7, 32'd10, 32'd15, 32'd22};
        sel = 0; accum = 1'b0;
        set4(1, 2, 3, 4, 1, 2, 3, 4);
        load(4, 4);
        wait_valid();
        tests++; if (lat != 6) begin fails++; $display("FAIL basic_latency got=%0d exp=6", lat); end
        tests++; if (busy_n != 5) begin fails++; $display("FAIL basic_busy_cycles got=%0d exp=5", busy_n); end
        take(4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin fails++; $display("FAIL basic_c%0d got=%0d exp=%0d", i, got[i], exp_v[i]); end
        end
        tests++; if (obs_state !== 2'd0) begin fails++; $display("FAIL basic_back_to_load got=%0d exp=0", obs_state); end
        tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_after got=%0b exp=1", obs_ready); end
    endtask

    task automatic test_accumulate();
        logic [31:0] exp_v [4];
        exp_v = '{32'd14, 32'd20, 32'd30, 32'd44};
        sel = 0; accum = 1'b1;
        load(4, 4);
        wait_valid();
        take(4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin fails++; $display("FAIL accum_c%0d got=%0d exp=%0d", i, got[i], exp_v[i]); end
        end
    endtask

    task automatic test_flush_clear();
        logic [31:0] exp_v [4];
        exp_v = '{32'd7, 32'd10, 32'd15, 32'd22};
        sel = 0; accum = 1'b1;
        flush = 1'b1; vin = 1'b1; din = 8'h55;
        #1;
        tests++; if (obs_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got=%0b exp=0", obs_ready); end
        @(negedge clk);
        flush = 1'b0; vin = 1'b0;
        load(4, 4);
        wait_valid();
        take(4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin fails++; $display("FAIL flush_accum_c%0d got=%0d exp=%0d", i, got[i], exp_v[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_v [4];
        exp_v = '{32'd7, 32'd10, 32'd15, 32'd22};
        sel = 0; accum = 1'b0;
        load(4, 4);
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            tests++; if (obs_data !== 32'd7) begin fails++; $display("FAIL bp_hold_data cyc%0d got=%0d exp=7", i, obs_data); end
            tests++; if (obs_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cyc%0d got=%0b exp=1", i, obs_valid); end
            tests++; if (obs_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_ready cyc%0d got=%0b exp=0", i, obs_ready); end
            @(negedge clk); #1;
        end
        // A yumi during a stall must not advance the drain index.
        en = 1'b0; yumi = 1'b1;
        #1;
        tests++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL bp_stall_valid got=%0b exp=0", obs_valid); end
        @(negedge clk);
        en = 1'b1; yumi = 1'b0;
        #1;
        tests++; if (obs_data !== 32'd7) begin fails++; $display("FAIL bp_after_stall_data got=%0d exp=7", obs_data); end
        take(4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin fails++; $display("FAIL bp_c%0d got=%0d exp=%0d", i, got[i], exp_v[i]); end
        end
        tests++; if (rdy_seen !== 1'b0) begin fails++; $display("FAIL bp_ready_in_drain got=%0b exp=0", rdy_seen); end
        tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after got=%0b exp=1", obs_ready); end
    endtask

    task automatic test_flush_load_b();
        logic [31:0] exp_v [4];
        exp_v = '{32'd7, 32'd10, 32'd15, 32'd22};
        sel = 0; accum = 1'b0;
        set4(9, 9, 9, 9, 9, 9, 9, 9);
        load(4, 2);
        #1;
        tests++; if (obs_state !== 2'd1) begin fails++; $display("FAIL flb_state_before got=%0d exp=1", obs_state); end
        flush = 1'b1; vin = 1'b1; din = 8'h09;
        #1;
        tests++; if (obs_ready !== 1'b0) begin fails++; $display("FAIL flb_ready got=%0b exp=0", obs_ready); end
        @(negedge clk);
        flush = 1'b0; vin = 1'b0;
        #1;
        tests++; if (obs_state !== 2'd0) begin fails++; $display("FAIL flb_state_after got=%0d exp=0", obs_state); end
        set4(1, 2, 3, 4, 1, 2, 3, 4);
        load(4, 4);
        wait_valid();
        take(4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin fails++; $display("FAIL flb_c%0d got=%0d exp=%0d", i, got[i], exp_v[i]); end
        end
    endtask

    task automatic test_signed();
        logic [31:0] exp_v [4];
        exp_v = '{32'h0000FFFF, 32'h00000002, 32'h00000003, 32'h0000FFFC};
        sel = 1; accum = 1'b0;
        set4(8'hFF, 8'h02, 8'h03, 8'hFC, 8'h01, 8'h00, 8'h00, 8'h01);
        load(4, 4);
        wait_valid();
        tests++; if (lat != 6) begin fails++; $display("FAIL signed_latency got=%0d exp=6", lat); end
        take(4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin fails++; $display("FAIL signed_c%0d got=%0h exp=%0h", i, got[i], exp_v[i]); end
        end
    endtask

    task automatic test_rect();
        int n;
        sel = 2; accum = 1'b0;
        for (int i = 0; i < 6; i++) a_v[i] = 8'(i + 1);
        b_v[0] = 1; b_v[1] = 1; b_v[2] = 1;
        load(6, 3);
        wait_valid();
        tests++; if (lat != 6) begin fails++; $display("FAIL rect_latency got=%0d exp=6", lat); end
        take(2);
        tests++; if (got[0] !== 32'd6) begin fails++; $display("FAIL rect_c0 got=%0d exp=6", got[0]); end
        tests++; if (got[1] !== 32'd15) begin fails++; $display("FAIL rect_c1 got=%0d exp=15", got[1]); end
        // Same problem with a 3-cycle stall two cycles into COMPUTE.
        load(6, 3);
        n = 0;
        @(negedge clk); n++;
        @(negedge clk); n++;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1; n++;
            tests++; if (obs_state !== 2'd2) begin fails++; $display("FAIL rect_stall_state cyc%0d got=%0d exp=2", i, obs_state); end
        end
        en = 1'b1;
        #1;
        while (!obs_valid && n < 200) begin
            @(negedge clk); #1; n++;
        end
        tests++; if (n != 9) begin fails++; $display("FAIL rect_stall_latency got=%0d exp=9", n); end
        take(2);
        tests++; if (got[0] !== 32'd6) begin fails++; $display("FAIL rect_stall_c0 got=%0d exp=6", got[0]); end
        tests++; if (got[1] !== 32'd15) begin fails++; $display("FAIL rect_stall_c1 got=%0d exp=15", got[1]); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_v [4];
        sel = 3; accum = 1'b0;
        exp_v = '{32'd0, 32'd0, 32'd0, 32'd0};
        set4(16, 0, 0, 0, 16, 0, 0, 0);
        load(4, 4);
        wait_valid();
        take(4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin fails++; $display("FAIL wrap_c%0d got=%0d exp=%0d", i, got[i], exp_v[i]); end
        end
        // 16*16 + 1*1 = 257, which wraps to 1 in 8 bits.
        exp_v = '{32'd1, 32'd0, 32'd0, 32'd0};
        set4(16, 1, 0, 0, 16, 0, 1, 0);
        load(4, 4);
        wait_valid();
        take(4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin fails++; $display("FAIL wrap2_c%0d got=%0d exp=%0d", i, got[i], exp_v[i]); end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_accumulate();
        test_flush_clear();
        test_backpressure();
        test_flush_load_b();
        test_signed();
        test_rect();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout tests=%0d required completion", tests);
        $fatal(1, "watchdog");
    end

endmodule
